wash_seq_ctrl: RTL and testbench
================================

# wash_seq_ctrl

Parametrised washing-machine sequencer and the successor to the fixed-timing `TopMach` controller. It is a single-clock Moore FSM with phase timers. It adds configurable phase durations, a multi-coin price with credit accumulation, and a selectable number of wash/rinse repetitions that generalises the old double-wash button. It also exposes live status (state, remaining phase cycles, credit) for a display or supervisor block.

## Interface
- CNT_W, 8: phase timer width; every T_* must satisfy 1 ≤ T_* ≤ 2^CNT_W.
- T_SOAK, 20: SOAK duration in clock cycles.
- T_WASH, 40: duration of each WASH phase in cycles.
- T_RINSE, 20: duration of each RINSE phase in cycles.
- T_SPIN, 30: SPIN duration in cycles, excluding lid pauses.
- PRICE, 1: coins needed per cycle; must be ≥ 1 and ≤ 2^CRED_W−1.
- CRED_W, 4: credit counter width.
- MAX_REPS, 3: maximum wash/rinse repetitions; must be ≥ 1.
- REP_W, 2: width of I_REPS; must satisfy 2^REP_W > MAX_REPS.
- CLK  in  1  clock; all logic is on the rising edge.
- RST  in  1  synchronous, active-low reset.
- I_COIN  in  1  coin sensor; each 0→1 transition between consecutive samples is one coin.
- I_LID  in  1  lid open, level-sensitive.
- I_REPS  in  REP_W  requested wash/rinse repetitions; latched at start.
- DN  out  1  one-cycle done pulse.
- O_STATE  out  3  current state encoding.
- O_REMAIN  out  CNT_W  cycles remaining in the current phase, minus one.
- O_CREDIT  out  CRED_W  accumulated coins.

## Operation
- States and O_STATE encoding: IDLE=0, SOAK=1, WASH=2, RINSE=3, SPIN=4, DONE=5. Codes 6 and 7 are illegal; the FSM goes to IDLE on the next edge.
- Coin detect:
  - A registered copy of I_COIN gives coin_edge = I_COIN & ~coin_q.
  - The next credit is credit + coin_edge − (start ? PRICE : 0).
  - The increment saturates at 2^CRED_W−1.
- Start: in IDLE, when credit ≥ PRICE, go to SOAK on the next edge. On that same edge:
  - latch reps = (I_REPS == 0) ? 1 : min(I_REPS, MAX_REPS);
  - clear rep_cnt to 1;
  - debit PRICE from credit. A coin edge in the same cycle is still counted, so surplus credit carries over to the next cycle.
- Phase timer: on entry to each timed phase, load T_x−1. It decrements every cycle. The phase exits on the edge where the timer is 0, so each phase lasts exactly T_x cycles.
- Transitions:
  - SOAK→WASH.
  - WASH→RINSE.
  - RINSE→WASH if rep_cnt < reps, incrementing rep_cnt; otherwise RINSE→SPIN.
  - SPIN→DONE.
  - DONE→IDLE unconditionally.
- Lid behaviour:
  - I_LID is ignored in SOAK, WASH, RINSE, DONE and IDLE.
  - In SPIN, I_LID=1 freezes the timer and blocks the exit, even when the timer is 0.
  - Counting resumes on the first cycle with I_LID=0.
- DN=1 exactly while the state is DONE, which is one cycle per completed run.
- O_REMAIN is the live timer value in SOAK, WASH, RINSE and SPIN, and 0 in IDLE and DONE.
- Coins arriving during a run accumulate into credit. If credit ≥ PRICE on the IDLE cycle after DONE, the next run starts immediately.

## Timing
- Reset (RST=0 at an edge), whether at power-up or mid-run:
  - state=IDLE, credit=0, timer=0, coin_q=0, rep_cnt=0, reps=1;
  - outputs: DN=0, O_STATE=0, O_REMAIN=0, O_CREDIT=0.
  - Reset has priority over all other events.
- Coin-to-start latency: coin_edge sampled at edge k → credit visible after k → SOAK after edge k+1 (with PRICE already met).
- Run length from SOAK entry to DONE entry: T_SOAK + reps·(T_WASH+T_RINSE) + T_SPIN + N_lid, where N_lid is the number of SPIN cycles with I_LID=1. DN follows for one cycle, then IDLE.
- A coin held high across several cycles counts once. Coin toggling every cycle counts one coin per rise.
- Because I_REPS is sampled only at the start edge, changing it mid-run has no effect.

## Test plan
- Single run with defaults: one coin pulse at edge k, I_REPS=1 → SOAK after edge k+1. DN high for exactly one cycle, 110 cycles after SOAK entry. O_CREDIT returns to 0. O_STATE sequence is 0,1,2,3,4,5,0.
- Repetitions:
  - I_REPS=2 → run is 170 cycles with WASH/RINSE visited twice.
  - I_REPS=0 → same as 1 (110 cycles).
  - I_REPS=3 with MAX_REPS=2 (override) → clamped to 2.
- Lid:
  - I_LID=1 for 10 cycles in each of SOAK, WASH and RINSE → no change in run length.
  - I_LID=1 for 10 cycles in SPIN → DN 10 cycles later.
  - Lid held from SPIN entry → O_REMAIN stays at T_SPIN−1.
- Pricing with PRICE=3:
  - 2 coins → stays IDLE with O_CREDIT=2.
  - 3rd coin → start, O_CREDIT=0.
  - 4 coins during a run → credit 4. After DONE, auto-start on the next IDLE cycle with credit 1.
- Credit edge cases:
  - I_COIN held high for 50 cycles → counts one coin.
  - 20 coin pulses with CRED_W=4 → O_CREDIT saturates at 15.
- Reset: drive RST=0 for one edge in WASH with credit 2 → next cycle all outputs are 0 and state=IDLE. No DN pulse follows.

Source files
------------

// File: rtl/wash_seq_ctrl.sv
// wash_seq_ctrl: washing-machine sequencer with coin credit, configurable
// phase durations and wash/rinse repetitions.
// State flow: IDLE -> SOAK -> (WASH -> RINSE) x reps -> SPIN -> DONE -> IDLE.
module wash_seq_ctrl #(
  parameter int CNT_W    = 8,
  parameter int T_SOAK   = 20,
  parameter int T_WASH   = 40,
  parameter int T_RINSE  = 20,
  parameter int T_SPIN   = 30,
  parameter int PRICE    = 1,
  parameter int CRED_W   = 4,
  parameter int MAX_REPS = 3,
  parameter int REP_W    = 2
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              I_COIN,
  input  logic              I_LID,
  input  logic [REP_W-1:0]  I_REPS,
  output logic              DN,
  output logic [2:0]        O_STATE,
  output logic [CNT_W-1:0]  O_REMAIN,
  output logic [CRED_W-1:0] O_CREDIT
);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_SOAK  = 3'd1,
    ST_WASH  = 3'd2,
    ST_RINSE = 3'd3,
    ST_SPIN  = 3'd4,
    ST_DONE  = 3'd5
  } state_t;

  // Timer reload values: a phase of T cycles counts T-1 down to 0.
  localparam logic [CNT_W-1:0]  LP_LD_SOAK  = CNT_W'(T_SOAK - 1);
  localparam logic [CNT_W-1:0]  LP_LD_WASH  = CNT_W'(T_WASH - 1);
  localparam logic [CNT_W-1:0]  LP_LD_RINSE = CNT_W'(T_RINSE - 1);
  localparam logic [CNT_W-1:0]  LP_LD_SPIN  = CNT_W'(T_SPIN - 1);
  localparam logic [CRED_W-1:0] LP_PRICE    = CRED_W'(PRICE);
  localparam logic [CRED_W-1:0] LP_CRED_MAX = '1;
  localparam logic [REP_W-1:0]  LP_MAX_REPS = REP_W'(MAX_REPS);
  localparam logic [REP_W-1:0]  LP_ONE_REP  = REP_W'(1);

  state_t             r_state;
  state_t             w_next;
  logic               r_coin_q;
  logic [CRED_W-1:0]  r_credit;
  logic [CNT_W-1:0]   r_timer;
  logic [REP_W-1:0]   r_reps;
  logic [REP_W-1:0]   r_rep_cnt;

  logic               w_coin_edge;
  logic               w_start;
  logic               w_timed;
  logic               w_timer_zero;
  logic               w_spin_hold;
  logic [CRED_W-1:0]  w_credit_inc;
  logic [CRED_W-1:0]  w_credit_nxt;
  logic [REP_W-1:0]   w_reps_sel;
  logic [CNT_W-1:0]   w_timer_nxt;

  assign w_coin_edge  = I_COIN & ~r_coin_q;
  assign w_start      = (r_state == ST_IDLE) && (r_credit >= LP_PRICE);
  assign w_timed      = (r_state == ST_SOAK) || (r_state == ST_WASH) ||
                        (r_state == ST_RINSE) || (r_state == ST_SPIN);
  assign w_timer_zero = (r_timer == '0);
  assign w_spin_hold  = (r_state == ST_SPIN) && I_LID;

  // Credit update: saturating coin increment, then debit on the start edge.
  always_comb begin
    w_credit_inc = r_credit;
    if (w_coin_edge && (r_credit != LP_CRED_MAX)) begin
      w_credit_inc = r_credit + CRED_W'(1);
    end
    w_credit_nxt = w_credit_inc;
    if (w_start) begin
      w_credit_nxt = w_credit_inc - LP_PRICE;
    end
  end

  // Repetition request clamped to 1..MAX_REPS.
  always_comb begin
    w_reps_sel = I_REPS;
    if (I_REPS == '0) begin
      w_reps_sel = LP_ONE_REP;
    end else if (I_REPS > LP_MAX_REPS) begin
      w_reps_sel = LP_MAX_REPS;
    end
  end

  // State register.
  always_ff @(posedge CLK) begin
    if (!RST) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Next-state logic; illegal encodings fall back to IDLE.
  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE:  if (w_start) w_next = ST_SOAK;
      ST_SOAK:  if (w_timer_zero) w_next = ST_WASH;
      ST_WASH:  if (w_timer_zero) w_next = ST_RINSE;
      ST_RINSE: begin
        if (w_timer_zero) begin
          w_next = (r_rep_cnt < r_reps) ? ST_WASH : ST_SPIN;
        end
      end
      ST_SPIN:  if (w_timer_zero && !I_LID) w_next = ST_DONE;
      ST_DONE:  w_next = ST_IDLE;
      default:  w_next = ST_IDLE;
    endcase
  end

  // Phase timer: reload on any state change, count down inside a phase,
  // freeze while the lid is open during SPIN.
  always_comb begin
    w_timer_nxt = r_timer;
    if (w_next != r_state) begin
      case (w_next)
        ST_SOAK:  w_timer_nxt = LP_LD_SOAK;
        ST_WASH:  w_timer_nxt = LP_LD_WASH;
        ST_RINSE: w_timer_nxt = LP_LD_RINSE;
        ST_SPIN:  w_timer_nxt = LP_LD_SPIN;
        default:  w_timer_nxt = '0;
      endcase
    end else if (w_timed && !w_spin_hold && !w_timer_zero) begin
      w_timer_nxt = r_timer - CNT_W'(1);
    end
  end

  // Datapath registers: coin sampler, credit, timer, repetition tracking.
  always_ff @(posedge CLK) begin
    if (!RST) begin
      r_coin_q  <= 1'b0;
      r_credit  <= '0;
      r_timer   <= '0;
      r_reps    <= LP_ONE_REP;
      r_rep_cnt <= '0;
    end else begin
      r_coin_q <= I_COIN;
      r_credit <= w_credit_nxt;
      r_timer  <= w_timer_nxt;
      if (w_start) begin
        r_reps    <= w_reps_sel;
        r_rep_cnt <= LP_ONE_REP;
      end else if ((r_state == ST_RINSE) && (w_next == ST_WASH)) begin
        r_rep_cnt <= r_rep_cnt + LP_ONE_REP;
      end
    end
  end

  // Moore outputs.
  always_comb begin
    DN       = (r_state == ST_DONE);
    O_STATE  = r_state;
    O_REMAIN = w_timed ? r_timer : '0;
    O_CREDIT = r_credit;
  end

endmodule

// File: tb/tb_wash_seq_ctrl.sv
// Directed bench for wash_seq_ctrl: a default instance (index 0) and a
// PRICE=3 / MAX_REPS=2 instance (index 1). Expected run results are queued
// when a run is started and popped when the run reaches DONE.
module tb_wash_seq_ctrl;

  logic       CLK = 1'b0;
  always #5 CLK = ~CLK;

  logic       rst  [2];
  logic       coin [2];
  logic       lid  [2];
  logic [1:0] reps [2];
  logic       dn   [2];
  logic [2:0] st   [2];
  logic [7:0] rem  [2];
  logic [3:0] cred [2];

  int checks   = 0;
  int failures = 0;

  typedef struct {
    int          len;
    logic [31:0] sig;
    int          cred;
  } exp_t;

  exp_t exp_q[$];

  wash_seq_ctrl u_dut0 (
    .CLK      (CLK),
    .RST      (rst[0]),
    .I_COIN   (coin[0]),
    .I_LID    (lid[0]),
    .I_REPS   (reps[0]),
    .DN       (dn[0]),
    .O_STATE  (st[0]),
    .O_REMAIN (rem[0]),
    .O_CREDIT (cred[0])
  );

  wash_seq_ctrl #(
    .PRICE    (3),
    .MAX_REPS (2)
  ) u_dut3 (
    .CLK      (CLK),
    .RST      (rst[1]),
    .I_COIN   (coin[1]),
    .I_LID    (lid[1]),
    .I_REPS   (reps[1]),
    .DN       (dn[1]),
    .O_STATE  (st[1]),
    .O_REMAIN (rem[1]),
    .O_CREDIT (cred[1])
  );

  task automatic tick;
    @(posedge CLK);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp_v);
    end
  endtask

  task automatic coin_pulse(input int d);
    coin[d] = 1'b1;
    tick;
    coin[d] = 1'b0;
    tick;
  endtask

  task automatic do_reset(input int d);
    rst[d]  = 1'b0;
    coin[d] = 1'b0;
    lid[d]  = 1'b0;
    tick;
    tick;
    rst[d] = 1'b1;
  endtask

  // Runs from an observed SOAK state to DONE, optionally opening the lid
  // for lid_len cycles of each visit to a masked state and dropping coins.
  task automatic measure(input int d, input logic [7:0] lid_mask, input int lid_len,
                         input int n_coins, input string tag);
    exp_t        e;
    int          cycles;
    int          lid_cnt;
    int          coin_cnt;
    logic [31:0] sig;
    logic [2:0]  prev;
    bit          rem_done;
    e        = exp_q.pop_front();
    cycles   = 0;
    lid_cnt  = 0;
    coin_cnt = 0;
    sig      = {29'd0, st[d]};
    prev     = st[d];
    rem_done = 1'b0;
    while ((st[d] != 3'd5) && (cycles < 1000)) begin
      if ((st[d] == 3'd4) && lid_mask[4] && (lid_cnt == lid_len) && !rem_done) begin
        chk({tag, "_spin_remain_frozen"}, 32'(rem[d]), 32'd29);
        rem_done = 1'b1;
      end
      if (lid_mask[st[d]] && (lid_cnt < lid_len)) begin
        lid[d] = 1'b1;
        lid_cnt++;
      end else begin
        lid[d] = 1'b0;
      end
      if (((cycles % 4) == 2) && (coin_cnt < n_coins)) begin
        coin[d] = 1'b1;
        coin_cnt++;
      end else begin
        coin[d] = 1'b0;
      end
      tick;
      cycles++;
      if (st[d] != prev) begin
        sig     = {sig[28:0], st[d]};
        prev    = st[d];
        lid_cnt = 0;
      end
    end
    lid[d]  = 1'b0;
    coin[d] = 1'b0;
    chk({tag, "_run_len"},        32'(cycles), 32'(e.len));
    chk({tag, "_dn_in_done"},     32'(dn[d]),  32'd1);
    chk({tag, "_remain_in_done"}, 32'(rem[d]), 32'd0);
    chk({tag, "_credit_at_done"}, 32'(cred[d]), 32'(e.cred));
    tick;
    sig = {sig[28:0], st[d]};
    chk({tag, "_state_seq"},      sig,         e.sig);
    chk({tag, "_dn_after_done"},  32'(dn[d]),  32'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int dn_seen;
    for (int unsigned i = 0; i < 2; i++) begin
      rst[i]  = 1'b0;
      coin[i] = 1'b0;
      lid[i]  = 1'b0;
      reps[i] = 2'd1;
    end
    tick;
    tick;
    chk("reset_state",  32'(st[0]),   32'd0);
    chk("reset_remain", 32'(rem[0]),  32'd0);
    chk("reset_credit", 32'(cred[0]), 32'd0);
    chk("reset_dn",     32'(dn[0]),   32'd0);
    rst[0] = 1'b1;
    rst[1] = 1'b1;
    tick;

    // Single default run: coin edge at k, SOAK after k+1.
    coin[0] = 1'b1;
    tick;
    chk("coin_credit", 32'(cred[0]), 32'd1);
    chk("coin_idle",   32'(st[0]),   32'd0);
    coin[0] = 1'b0;
    tick;
    chk("start_soak",   32'(st[0]),   32'd1);
    chk("start_credit", 32'(cred[0]), 32'd0);
    chk("start_remain", 32'(rem[0]),  32'd19);
    exp_q.push_back('{len: 110, sig: 32'o123450, cred: 0});
    measure(0, 8'h00, 0, 0, "run1");

    // Two repetitions.
    reps[0] = 2'd2;
    coin_pulse(0);
    exp_q.push_back('{len: 170, sig: 32'o12323450, cred: 0});
    measure(0, 8'h00, 0, 0, "reps2");

    // Zero repetitions behaves as one; a mid-run change is ignored.
    reps[0] = 2'd0;
    coin_pulse(0);
    reps[0] = 2'd3;
    exp_q.push_back('{len: 110, sig: 32'o123450, cred: 0});
    measure(0, 8'h00, 0, 0, "reps0");

    // Lid ignored in SOAK, WASH, RINSE.
    reps[0] = 2'd1;
    coin_pulse(0);
    exp_q.push_back('{len: 110, sig: 32'o123450, cred: 0});
    measure(0, 8'b0000_1110, 10, 0, "lid_phases");

    // Lid in SPIN extends the run and freezes the timer.
    coin_pulse(0);
    exp_q.push_back('{len: 120, sig: 32'o123450, cred: 0});
    measure(0, 8'b0001_0000, 10, 0, "lid_spin");

    // Credit saturation during a run.
    coin_pulse(0);
    exp_q.push_back('{len: 110, sig: 32'o123450, cred: 15});
    measure(0, 8'h00, 0, 20, "sat");
    do_reset(0);
    chk("sat_reset_credit", 32'(cred[0]), 32'd0);

    // Reset in WASH with credit 2.
    coin_pulse(0);
    coin_pulse(0);
    coin_pulse(0);
    for (int unsigned i = 0; (i < 100) && (st[0] != 3'd2); i++) tick;
    chk("mid_wash_state",  32'(st[0]),   32'd2);
    chk("mid_wash_credit", 32'(cred[0]), 32'd2);
    rst[0] = 1'b0;
    tick;
    chk("midrst_state",  32'(st[0]),   32'd0);
    chk("midrst_remain", 32'(rem[0]),  32'd0);
    chk("midrst_credit", 32'(cred[0]), 32'd0);
    chk("midrst_dn",     32'(dn[0]),   32'd0);
    rst[0] = 1'b1;
    dn_seen = 0;
    for (int unsigned i = 0; i < 200; i++) begin
      tick;
      if (dn[0]) dn_seen++;
    end
    chk("midrst_no_dn",     32'(dn_seen), 32'd0);
    chk("midrst_stay_idle", 32'(st[0]),   32'd0);

    // PRICE=3 instance: held coin counts once, partial credit waits.
    do_reset(1);
    reps[1] = 2'd3;
    coin[1] = 1'b1;
    for (int unsigned i = 0; i < 50; i++) tick;
    coin[1] = 1'b0;
    tick;
    chk("held_coin_credit", 32'(cred[1]), 32'd1);
    chk("held_coin_idle",   32'(st[1]),   32'd0);
    coin_pulse(1);
    for (int unsigned i = 0; i < 5; i++) tick;
    chk("two_coin_credit", 32'(cred[1]), 32'd2);
    chk("two_coin_idle",   32'(st[1]),   32'd0);
    coin[1] = 1'b1;
    tick;
    chk("three_coin_credit", 32'(cred[1]), 32'd3);
    coin[1] = 1'b0;
    tick;
    chk("price3_start",  32'(st[1]),   32'd1);
    chk("price3_debit",  32'(cred[1]), 32'd0);
    exp_q.push_back('{len: 170, sig: 32'o12323450, cred: 4});
    measure(1, 8'h00, 0, 4, "price3_clamp");
    chk("auto_idle_credit", 32'(cred[1]), 32'd4);
    tick;
    chk("auto_start_state",  32'(st[1]),   32'd1);
    chk("auto_start_credit", 32'(cred[1]), 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
